// File: rtl/free_list_mp.sv
// ---------------------------------------------------------------------------
// free_list_mp
//   Multi-port physical-register free list for the rename stage.
//   A circular buffer of free preg tags.  Each cycle up to WIDTH tags can be
//   allocated (dequeued) and up to WIDTH tags can be freed (enqueued).
//   Reset pre-loads every non-architectural preg (NUM_AREGS..NUM_PREGS-1).
//
//   Optional feature, enabled by defining FREE_LIST_CKPT_EN:
//     one head-pointer snapshot for branch-mispredict recovery
//     (ckpt_save / ckpt_restore ports).
//
// Parameters
//   NUM_PREGS  buffer depth = number of physical registers (power of two)
//   NUM_AREGS  number of architectural registers mapped at reset
//   WIDTH      number of dequeue ports = number of enqueue ports (1..4)
//
// Ports
//   clk           clock, all state updates on posedge
//   reset_n       synchronous active-low reset
//   deq_req       per-port allocation request
//   deq_valid     registered, port i was granted in the previous cycle
//   deq_pr        registered packed tags, port i at [i*PW +: PW], 0 if not valid
//   enq_en        per-port free request
//   enq_pr        packed tags being freed, port i at [i*PW +: PW]
//   enq_ack       registered, port i was accepted in the previous cycle
//   free_count    registered number of free tags (0..NUM_PREGS)
//   overflow_err  sticky, set when an enqueue is dropped; cleared by reset
//   ckpt_save     (FREE_LIST_CKPT_EN) snapshot head after this cycle's grants
//   ckpt_restore  (FREE_LIST_CKPT_EN) roll head back to the snapshot
//
// Handshake: deq_req and enq_en are fire-and-forget requests sampled at the
// posedge; there is no ready.  The outcome of a request is reported exactly
// one cycle later on deq_valid / enq_ack for the same port.  A request that
// is not granted (deq) or not accepted (enq) is simply lost and must be
// re-issued by the caller if still wanted.
// ---------------------------------------------------------------------------
module free_list_mp #(
   parameter int NUM_PREGS = 64,
   parameter int NUM_AREGS = 32,
   parameter int WIDTH     = 2,
   localparam int PW       = $clog2(NUM_PREGS)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [WIDTH-1:0]    deq_req,
   output logic [WIDTH-1:0]    deq_valid,
   output logic [WIDTH*PW-1:0] deq_pr,
   input  logic [WIDTH-1:0]    enq_en,
   input  logic [WIDTH*PW-1:0] enq_pr,
   output logic [WIDTH-1:0]    enq_ack,
   output logic [PW:0]         free_count,
   output logic                overflow_err
`ifdef FREE_LIST_CKPT_EN
   ,
   input  logic                ckpt_save,
   input  logic                ckpt_restore
`endif
);

   localparam int CW       = PW + 1;   // count width, holds 0..NUM_PREGS
   localparam int XW       = PW + 2;   // headroom for capacity arithmetic
   localparam int NUM_INIT = NUM_PREGS - NUM_AREGS;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [PW-1:0]       mem_q [NUM_PREGS];
   logic [PW-1:0]       mem_d [NUM_PREGS];
   logic [PW-1:0]       head_q, head_d;
   logic [PW-1:0]       tail_q, tail_d;
   logic [CW-1:0]       count_q, count_d;
   logic [WIDTH-1:0]    deq_valid_q, deq_valid_d;
   logic [WIDTH*PW-1:0] deq_pr_q, deq_pr_d;
   logic [WIDTH-1:0]    enq_ack_q, enq_ack_d;
   logic                overflow_q, overflow_d;

   logic                restore_i;

`ifdef FREE_LIST_CKPT_EN
   logic [PW-1:0]       ckpt_head_q, ckpt_head_d;
   logic [PW-1:0]       restore_diff;
   logic                save_i;

   assign save_i    = ckpt_save;
   assign restore_i = ckpt_restore;
`else
   assign restore_i = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   logic [XW-1:0] req_seen;
   logic [XW-1:0] en_seen;
   logic [XW-1:0] n_grant;
   logic [XW-1:0] n_acc;
   logic [XW-1:0] cap;
   logic [XW-1:0] count_ext;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   always_comb begin
      mem_d       = mem_q;
      deq_valid_d = '0;
      deq_pr_d    = '0;
      enq_ack_d   = '0;
      overflow_d  = overflow_q;
      req_seen    = '0;
      en_seen     = '0;
      n_grant     = '0;
      n_acc       = '0;
      rd_ptr      = head_q;
      wr_ptr      = tail_q;
      count_ext   = XW'(count_q);

      // Dequeue: the k-th requesting port (in port order) is granted when
      // k <= count at the start of the cycle.  Grants therefore form a
      // prefix of the requesters and take consecutive entries from head.
      // A restore cancels every allocation this cycle.
      for (int i = 0; i < WIDTH; i++) begin
         if (deq_req[i] && !restore_i) begin
            req_seen = req_seen + XW'(1);
            if (req_seen <= count_ext) begin
               deq_valid_d[i]        = 1'b1;
               deq_pr_d[i*PW +: PW]  = mem_q[rd_ptr];
               rd_ptr                = rd_ptr + PW'(1);
               n_grant               = n_grant + XW'(1);
            end
         end
      end

      // Enqueue: slots vacated by this cycle's grants are reusable now,
      // because reads above use the pre-update array (no bypass).
      cap = XW'(NUM_PREGS) - count_ext + n_grant;
      for (int i = 0; i < WIDTH; i++) begin
         if (enq_en[i]) begin
            en_seen = en_seen + XW'(1);
            if (en_seen <= cap) begin
               enq_ack_d[i]  = 1'b1;
               mem_d[wr_ptr] = enq_pr[i*PW +: PW];
               wr_ptr        = wr_ptr + PW'(1);
               n_acc         = n_acc + XW'(1);
            end else begin
               overflow_d = 1'b1;
            end
         end
      end

      head_d  = rd_ptr;
      tail_d  = wr_ptr;
      count_d = CW'(count_ext - n_grant + n_acc);

`ifdef FREE_LIST_CKPT_EN
      ckpt_head_d  = ckpt_head_q;
      restore_diff = wr_ptr - ckpt_head_q;
      if (restore_i) begin
         // Everything from the snapshot up to the new tail is free again.
         // Equal pointers mean either completely full or completely empty;
         // the list cannot become empty by restoring unless it already was.
         head_d = ckpt_head_q;
         if (restore_diff == '0) begin
            count_d = ((count_ext + n_acc) != '0) ? CW'(NUM_PREGS) : '0;
         end else begin
            count_d = CW'(restore_diff);
         end
      end else if (save_i) begin
         ckpt_head_d = rd_ptr;
      end
`endif
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_PREGS; k++) begin
            mem_q[k] <= (k < NUM_INIT) ? PW'(NUM_AREGS + k) : '0;
         end
         head_q      <= '0;
         tail_q      <= PW'(NUM_INIT);
         count_q     <= CW'(NUM_INIT);
         deq_valid_q <= '0;
         deq_pr_q    <= '0;
         enq_ack_q   <= '0;
         overflow_q  <= 1'b0;
`ifdef FREE_LIST_CKPT_EN
         ckpt_head_q <= '0;
`endif
      end else begin
         mem_q       <= mem_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         deq_valid_q <= deq_valid_d;
         deq_pr_q    <= deq_pr_d;
         enq_ack_q   <= enq_ack_d;
         overflow_q  <= overflow_d;
`ifdef FREE_LIST_CKPT_EN
         ckpt_head_q <= ckpt_head_d;
`endif
      end
   end

   assign deq_valid    = deq_valid_q;
   assign deq_pr       = deq_pr_q;
   assign enq_ack      = enq_ack_q;
   assign free_count   = count_q;
   assign overflow_err = overflow_q;

endmodule

// File: tb/tb_free_list_mp.sv
// ---------------------------------------------------------------------------
// tb_free_list_mp
//   Self-checking bench for free_list_mp (NUM_PREGS=64, NUM_AREGS=32,
//   WIDTH=2).  The reference model is a plain queue of free tags: grants pop
//   from the front, frees push to the back while fewer than 64 tags are
//   held, and a checkpoint restore pushes the tags handed out since the
//   last save back onto the front.
// ---------------------------------------------------------------------------
module tb_free_list_mp;

   localparam int NP = 64;
   localparam int NA = 32;
   localparam int W  = 2;
   localparam int PW = 6;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset_n;
   logic [W-1:0]    deq_req;
   logic [W-1:0]    deq_valid;
   logic [W*PW-1:0] deq_pr;
   logic [W-1:0]    enq_en;
   logic [W*PW-1:0] enq_pr;
   logic [W-1:0]    enq_ack;
   logic [PW:0]     free_count;
   logic            overflow_err;
`ifdef FREE_LIST_CKPT_EN
   logic            ckpt_save;
   logic            ckpt_restore;
`endif

   free_list_mp #(.NUM_PREGS(NP), .NUM_AREGS(NA), .WIDTH(W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .deq_req      (deq_req),
      .deq_valid    (deq_valid),
      .deq_pr       (deq_pr),
      .enq_en       (enq_en),
      .enq_pr       (enq_pr),
      .enq_ack      (enq_ack),
      .free_count   (free_count),
      .overflow_err (overflow_err)
`ifdef FREE_LIST_CKPT_EN
      ,
      .ckpt_save    (ckpt_save),
      .ckpt_restore (ckpt_restore)
`endif
   );

   // ---------------- reference model + scoreboard ----------------
   int               free_q[$];
   int               since_save[$];
   logic [PW-1:0]    exp_q[$];
   bit               m_ovf;

   logic [W-1:0]     exp_valid;
   logic [W-1:0]     exp_ack;
   logic [W*PW-1:0]  exp_pr;
   int               exp_count;
   bit               exp_ovf;

   int errors = 0;
   int checks = 0;

   task automatic model_reset();
      free_q.delete();
      since_save.delete();
      exp_q.delete();
      for (int k = NA; k < NP; k++) free_q.push_back(k);
      m_ovf = 1'b0;
   endtask

   task automatic idle_inputs();
      deq_req = '0;
      enq_en  = '0;
      enq_pr  = '0;
`ifdef FREE_LIST_CKPT_EN
      ckpt_save    = 1'b0;
      ckpt_restore = 1'b0;
`endif
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
   endtask

   // Apply one cycle of stimulus, advance the model, and leave the expected
   // outputs (valid one cycle later) in the exp_* variables.
   task automatic drive_cycle(input logic [W-1:0] dreq, input logic [W-1:0] een,
                              input logic [W*PW-1:0] epr, input bit sv, input bit rs);
      logic [W-1:0]    v;
      logic [W-1:0]    a;
      logic [W*PW-1:0] p;
      int              t;
      v = '0;
      a = '0;
      p = '0;
      if (!rs) begin
         for (int i = 0; i < W; i++) begin
            if (dreq[i] && free_q.size() > 0) begin
               t = free_q.pop_front();
               v[i] = 1'b1;
               p[i*PW +: PW] = PW'(t);
               since_save.push_back(t);
               exp_q.push_back(PW'(t));
            end
         end
      end
      for (int i = 0; i < W; i++) begin
         if (een[i]) begin
            if (free_q.size() < NP) begin
               free_q.push_back(int'(epr[i*PW +: PW]));
               a[i] = 1'b1;
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
      if (rs) begin
         for (int j = since_save.size() - 1; j >= 0; j--) free_q.push_front(since_save[j]);
         since_save.delete();
      end else if (sv) begin
         since_save.delete();
      end

      deq_req = dreq;
      enq_en  = een;
      enq_pr  = epr;
`ifdef FREE_LIST_CKPT_EN
      ckpt_save    = sv;
      ckpt_restore = rs;
`endif
      @(posedge clk);
      #1;
      idle_inputs();
      exp_valid = v;
      exp_ack   = a;
      exp_pr    = p;
      exp_count = free_q.size();
      exp_ovf   = m_ovf;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      checks++;
      if (free_count !== 7'd32) begin
         errors++; $display("FAIL reset_count: got %0d want 32", free_count);
      end
      checks++;
      if (deq_valid !== 2'b00 || deq_pr !== '0) begin
         errors++; $display("FAIL reset_deq: got valid=%b pr=%h want 0/0", deq_valid, deq_pr);
      end
      checks++;
      if (enq_ack !== 2'b00 || overflow_err !== 1'b0) begin
         errors++; $display("FAIL reset_enq: got ack=%b ovf=%b want 0/0", enq_ack, overflow_err);
      end
   endtask

   task automatic test_first_alloc();
      logic [W*PW-1:0] want;
      want = {6'd33, 6'd32};
      drive_cycle(2'b11, 2'b00, '0, 1'b0, 1'b0);
      checks++;
      if (deq_valid !== 2'b11) begin
         errors++; $display("FAIL first_valid: got %b want 11", deq_valid);
      end
      checks++;
      if (deq_pr !== want) begin
         errors++; $display("FAIL first_pr: got %h want %h", deq_pr, want);
      end
      checks++;
      if (free_count !== 7'd30) begin
         errors++; $display("FAIL first_count: got %0d want 30", free_count);
      end
   endtask

   task automatic test_drain();
      for (int c = 0; c < 15; c++) begin
         drive_cycle(2'b11, 2'b00, '0, 1'b0, 1'b0);
         checks++;
         if (deq_valid !== exp_valid || deq_pr !== exp_pr || free_count !== exp_count[PW:0]) begin
            errors++;
            $display("FAIL drain_c%0d: got v=%b pr=%h cnt=%0d want v=%b pr=%h cnt=%0d",
                     c, deq_valid, deq_pr, free_count, exp_valid, exp_pr, exp_count);
         end
      end
      drive_cycle(2'b11, 2'b00, '0, 1'b0, 1'b0);
      checks++;
      if (deq_valid !== 2'b00 || deq_pr !== '0) begin
         errors++; $display("FAIL drain_empty: got v=%b pr=%h want 00/0", deq_valid, deq_pr);
      end
      checks++;
      if (free_count !== 7'd0) begin
         errors++; $display("FAIL drain_count: got %0d want 0", free_count);
      end
   endtask

   task automatic test_partial_grant();
      drive_cycle(2'b00, 2'b01, {6'd0, 6'd40}, 1'b0, 1'b0);
      checks++;
      if (enq_ack !== 2'b01 || free_count !== 7'd1) begin
         errors++; $display("FAIL partial_setup: got ack=%b cnt=%0d want 01/1", enq_ack, free_count);
      end
      drive_cycle(2'b11, 2'b00, '0, 1'b0, 1'b0);
      checks++;
      if (deq_valid !== 2'b01) begin
         errors++; $display("FAIL partial_valid: got %b want 01", deq_valid);
      end
      checks++;
      if (deq_pr[11:6] !== 6'd0 || deq_pr[5:0] !== 6'd40) begin
         errors++; $display("FAIL partial_pr: got %h want 028", deq_pr);
      end
      checks++;
      if (free_count !== 7'd0) begin
         errors++; $display("FAIL partial_count: got %0d want 0", free_count);
      end
   endtask

   task automatic test_empty_enq_deq();
      logic [W*PW-1:0] tags;
      tags = {6'd7, 6'd5};
      drive_cycle(2'b11, 2'b11, tags, 1'b0, 1'b0);
      checks++;
      if (deq_valid !== 2'b00 || enq_ack !== 2'b11 || free_count !== 7'd2) begin
         errors++; $display("FAIL empty_same_cycle: got v=%b ack=%b cnt=%0d want 00/11/2",
                            deq_valid, enq_ack, free_count);
      end
      drive_cycle(2'b11, 2'b00, '0, 1'b0, 1'b0);
      checks++;
      if (deq_valid !== 2'b11 || deq_pr !== tags) begin
         errors++; $display("FAIL empty_next_deq: got v=%b pr=%h want 11/%h", deq_valid, deq_pr, tags);
      end
   endtask

   task automatic test_overflow();
      logic [W*PW-1:0] tags;
      for (int c = 0; c < 32; c++) begin
         tags = {PW'(2*c + 11), PW'(2*c + 10)};
         drive_cycle(2'b00, (c == 31) ? 2'b01 : 2'b11, tags, 1'b0, 1'b0);
      end
      checks++;
      if (free_count !== 7'd63 || overflow_err !== 1'b0) begin
         errors++; $display("FAIL ovf_fill: got cnt=%0d ovf=%b want 63/0", free_count, overflow_err);
      end
      tags = {6'd9, 6'd8};
      drive_cycle(2'b00, 2'b11, tags, 1'b0, 1'b0);
      checks++;
      if (enq_ack !== 2'b01 || overflow_err !== 1'b1 || free_count !== 7'd64) begin
         errors++; $display("FAIL ovf_hit: got ack=%b ovf=%b cnt=%0d want 01/1/64",
                            enq_ack, overflow_err, free_count);
      end
      for (int c = 0; c < 32; c++) begin
         drive_cycle(2'b11, 2'b00, '0, 1'b0, 1'b0);
         checks++;
         if (deq_valid !== exp_valid || deq_pr !== exp_pr || free_count !== exp_count[PW:0]
             || overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_wrap_c%0d: got v=%b pr=%h cnt=%0d ovf=%b want v=%b pr=%h cnt=%0d ovf=1",
                     c, deq_valid, deq_pr, free_count, overflow_err, exp_valid, exp_pr, exp_count);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0]    dreq;
      logic [W-1:0]    een;
      logic [W*PW-1:0] epr;
      logic [PW-1:0]   want;
      exp_q.delete();
      for (int c = 0; c < 400; c++) begin
         dreq = W'($urandom_range(0, 3));
         een  = W'($urandom_range(0, 3));
         epr  = {PW'($urandom_range(0, NP - 1)), PW'($urandom_range(0, NP - 1))};
         drive_cycle(dreq, een, epr, 1'b0, 1'b0);
         checks++;
         if (deq_valid !== exp_valid || enq_ack !== exp_ack || free_count !== exp_count[PW:0]
             || overflow_err !== exp_ovf) begin
            errors++;
            $display("FAIL rand_ctl_c%0d: got v=%b ack=%b cnt=%0d ovf=%b want v=%b ack=%b cnt=%0d ovf=%b",
                     c, deq_valid, enq_ack, free_count, overflow_err, exp_valid, exp_ack, exp_count, exp_ovf);
         end
         for (int i = 0; i < W; i++) begin
            if (exp_valid[i]) begin
               want = exp_q.pop_front();
               checks++;
               if (deq_pr[i*PW +: PW] !== want) begin
                  errors++; $display("FAIL rand_tag_c%0d_p%0d: got %0d want %0d",
                                     c, i, deq_pr[i*PW +: PW], want);
               end
            end else begin
               checks++;
               if (deq_pr[i*PW +: PW] !== '0) begin
                  errors++; $display("FAIL rand_zero_c%0d_p%0d: got %0d want 0",
                                     c, i, deq_pr[i*PW +: PW]);
               end
            end
         end
      end
   endtask

`ifdef FREE_LIST_CKPT_EN
   task automatic test_ckpt();
      do_reset();
      drive_cycle(2'b00, 2'b00, '0, 1'b1, 1'b0);
      drive_cycle(2'b11, 2'b00, '0, 1'b0, 1'b0);
      drive_cycle(2'b11, 2'b00, '0, 1'b0, 1'b0);
      checks++;
      if (free_count !== 7'd28) begin
         errors++; $display("FAIL ckpt_alloc: got cnt=%0d want 28", free_count);
      end
      drive_cycle(2'b11, 2'b00, '0, 1'b0, 1'b1);
      checks++;
      if (deq_valid !== 2'b00 || free_count !== 7'd32 || free_count !== exp_count[PW:0]) begin
         errors++; $display("FAIL ckpt_restore: got v=%b cnt=%0d want 00/32", deq_valid, free_count);
      end
      drive_cycle(2'b01, 2'b00, '0, 1'b0, 1'b0);
      checks++;
      if (deq_valid !== 2'b01 || deq_pr[5:0] !== 6'd32) begin
         errors++; $display("FAIL ckpt_replay: got v=%b pr0=%0d want 01/32", deq_valid, deq_pr[5:0]);
      end
      // Save together with grants, free a tag, then restore with an enqueue.
      drive_cycle(2'b11, 2'b00, '0, 1'b1, 1'b0);
      drive_cycle(2'b11, 2'b01, {6'd0, 6'd3}, 1'b0, 1'b0);
      drive_cycle(2'b00, 2'b01, {6'd0, 6'd4}, 1'b0, 1'b1);
      checks++;
      if (free_count !== exp_count[PW:0] || enq_ack !== 2'b01) begin
         errors++; $display("FAIL ckpt_restore_enq: got cnt=%0d ack=%b want %0d/01",
                            free_count, enq_ack, exp_count);
      end
      drive_cycle(2'b11, 2'b00, '0, 1'b0, 1'b0);
      checks++;
      if (deq_valid !== exp_valid || deq_pr !== exp_pr) begin
         errors++; $display("FAIL ckpt_restore_deq: got v=%b pr=%h want v=%b pr=%h",
                            deq_valid, deq_pr, exp_valid, exp_pr);
      end
   endtask
`endif

   // ---------------- sequence + report ----------------
   initial begin
      idle_inputs();
      reset_n = 1'b0;
      test_reset();
      test_first_alloc();
      test_drain();
      test_partial_grant();
      test_empty_enq_deq();
      test_overflow();
      test_random();
`ifdef FREE_LIST_CKPT_EN
      test_ckpt();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
